// File: rtl/life_pkg.sv
// Shared constants and helpers for the life-like cell and the grid blocks.
package life_pkg;

  localparam int unsigned ST_DEAD  = 0;
  localparam int unsigned ST_ALIVE = 1;

  // Conway B3/S23 for the 8-neighbour Moore neighbourhood
  localparam logic [8:0] CONWAY_BIRTH   = 9'b0_0000_1000;
  localparam logic [8:0] CONWAY_SURVIVE = 9'b0_0000_1100;

  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/popcount_n.sv
// Population count of an N-bit vector; result is wide enough for N without overflow.
module popcount_n #(
  parameter int unsigned N  = 8,
  parameter int unsigned CW = $clog2(N + 1)
) (
  input  logic [N-1:0]  bits,
  output logic [CW-1:0] count
);

  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < N; i++) begin
      count = count + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/life_cell_gen.sv
// One cell of a "Generations" life-like automaton with runtime birth/survive masks,
// refractory dying states, a saturating age counter and a change flag.
module life_cell_gen
  import life_pkg::*;
#(
  parameter int unsigned N_NEIGHBORS = 8,
  parameter int unsigned NUM_STATES  = 2,
  parameter int unsigned AGE_W       = 8,
  localparam int unsigned SW = clog2_min1(NUM_STATES),
  localparam int unsigned CW = $clog2(N_NEIGHBORS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic                   load,
  input  logic [SW-1:0]          state_0,
  input  logic [N_NEIGHBORS:0]   birth_mask,
  input  logic [N_NEIGHBORS:0]   survive_mask,
  input  logic [N_NEIGHBORS-1:0] neighbors,
  output logic [SW-1:0]          state_d,
  output logic [SW-1:0]          state_q,
  output logic                   alive_q,
  output logic [AGE_W-1:0]       age_q,
  output logic                   changed_q
);

  logic [CW-1:0]    count;
  logic [SW-1:0]    load_val;
  logic [AGE_W-1:0] age_d;
  logic             cur_alive;
  logic             next_alive;

  popcount_n #(.N(N_NEIGHBORS), .CW(CW)) u_popcount (
    .bits  (neighbors),
    .count (count)
  );

  assign cur_alive  = (state_q == SW'(ST_ALIVE));
  assign next_alive = (state_d == SW'(ST_ALIVE));
  assign alive_q    = cur_alive;
  assign load_val   = (32'(state_0) >= NUM_STATES) ? '0 : state_0;

  // Dying states advance regardless of neighbours; the last one and any
  // out-of-range encoding fall back to dead.
  always_comb begin
    state_d = '0;
    if (state_q == SW'(ST_DEAD)) begin
      state_d = birth_mask[count] ? SW'(ST_ALIVE) : SW'(ST_DEAD);
    end else if (cur_alive) begin
      if (survive_mask[count])  state_d = SW'(ST_ALIVE);
      else if (NUM_STATES > 2)  state_d = SW'(2);
      else                      state_d = SW'(ST_DEAD);
    end else if (32'(state_q) < NUM_STATES - 1) begin
      state_d = state_q + SW'(1);
    end
  end

  always_comb begin
    age_d = '0;
    if (cur_alive && next_alive) age_d = (age_q == '1) ? age_q : age_q + AGE_W'(1);
    else if (next_alive)         age_d = AGE_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= '0;
      age_q     <= '0;
      changed_q <= 1'b0;
    end else if (load) begin
      state_q   <= load_val;
      age_q     <= (load_val == SW'(ST_ALIVE)) ? AGE_W'(1) : '0;
      changed_q <= 1'b0;
    end else if (ena) begin
      state_q   <= state_d;
      age_q     <= age_d;
      changed_q <= (state_d != state_q);
    end
  end

endmodule

// File: tb/tb_life_cell_gen.sv
// Directed-vector bench for life_cell_gen across several parameter sets.
module tb_life_cell_gen;
  import life_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  // A: Conway C=2, AGE_W=2
  logic       a_ena = 0, a_load = 0;
  logic [0:0] a_s0 = '0, a_sd, a_sq;
  logic [8:0] a_bm = CONWAY_BIRTH, a_sm = CONWAY_SURVIVE;
  logic [7:0] a_nb = '0;
  logic       a_alive, a_chg;
  logic [1:0] a_age;

  // B: C=4, B2/S-none
  logic       b_ena = 0, b_load = 0;
  logic [1:0] b_s0 = '0, b_sd, b_sq;
  logic [8:0] b_bm = 9'b0_0000_0100, b_sm = '0;
  logic [7:0] b_nb = '0;
  logic       b_alive, b_chg;
  logic [7:0] b_age;

  // C: C=3
  logic       c_ena = 0, c_load = 0;
  logic [1:0] c_s0 = '0, c_sd, c_sq;
  logic [8:0] c_bm = CONWAY_BIRTH, c_sm = CONWAY_SURVIVE;
  logic [7:0] c_nb = '0;
  logic       c_alive, c_chg;
  logic [7:0] c_age;

  // D: 24 neighbours, birth on exactly 24
  logic        d_ena = 0, d_load = 0;
  logic [0:0]  d_s0 = '0, d_sd, d_sq;
  logic [24:0] d_bm = 25'h100_0000, d_sm = '0;
  logic [23:0] d_nb = '0;
  logic        d_alive, d_chg;
  logic [7:0]  d_age;

  life_cell_gen #(.N_NEIGHBORS(8), .NUM_STATES(2), .AGE_W(2)) u_a (
    .clk(clk), .rst(rst), .ena(a_ena), .load(a_load), .state_0(a_s0),
    .birth_mask(a_bm), .survive_mask(a_sm), .neighbors(a_nb),
    .state_d(a_sd), .state_q(a_sq), .alive_q(a_alive), .age_q(a_age), .changed_q(a_chg));

  life_cell_gen #(.N_NEIGHBORS(8), .NUM_STATES(4), .AGE_W(8)) u_b (
    .clk(clk), .rst(rst), .ena(b_ena), .load(b_load), .state_0(b_s0),
    .birth_mask(b_bm), .survive_mask(b_sm), .neighbors(b_nb),
    .state_d(b_sd), .state_q(b_sq), .alive_q(b_alive), .age_q(b_age), .changed_q(b_chg));

  life_cell_gen #(.N_NEIGHBORS(8), .NUM_STATES(3), .AGE_W(8)) u_c (
    .clk(clk), .rst(rst), .ena(c_ena), .load(c_load), .state_0(c_s0),
    .birth_mask(c_bm), .survive_mask(c_sm), .neighbors(c_nb),
    .state_d(c_sd), .state_q(c_sq), .alive_q(c_alive), .age_q(c_age), .changed_q(c_chg));

  life_cell_gen #(.N_NEIGHBORS(24), .NUM_STATES(2), .AGE_W(8)) u_d (
    .clk(clk), .rst(rst), .ena(d_ena), .load(d_load), .state_0(d_s0),
    .birth_mask(d_bm), .survive_mask(d_sm), .neighbors(d_nb),
    .state_d(d_sd), .state_q(d_sq), .alive_q(d_alive), .age_q(d_age), .changed_q(d_chg));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned sat_exp [5] = '{2, 3, 3, 3, 3};

    #12;
    chk("rst_a_state", 32'(a_sq), 0);
    chk("rst_a_age",   32'(a_age), 0);
    chk("rst_a_chg",   32'(a_chg), 0);
    chk("rst_b_state", 32'(b_sq), 0);
    @(negedge clk);
    rst = 1'b1;

    // load beats ena: a step from dead with 0 neighbours would stay dead
    a_load = 1; a_ena = 1; a_s0 = 1; a_nb = '0;
    tick();
    a_load = 0; a_ena = 0;
    chk("load_state", 32'(a_sq), 1);
    chk("load_age",   32'(a_age), 1);
    chk("load_chg",   32'(a_chg), 0);
    chk("load_alive", 32'(a_alive), 1);

    // asynchronous reset, sampled well away from any clock edge
    #2 rst = 1'b0;
    #1;
    chk("arst_state", 32'(a_sq), 0);
    chk("arst_age",   32'(a_age), 0);
    chk("arst_chg",   32'(a_chg), 0);
    @(negedge clk);
    rst = 1'b1;

    // Conway birth on 3
    a_nb = 8'b0000_0111;
    #1 chk("birth_sd", 32'(a_sd), 1);
    a_ena = 1;
    tick();
    chk("birth_state", 32'(a_sq), 1);
    chk("birth_age",   32'(a_age), 1);
    chk("birth_chg",   32'(a_chg), 1);

    // overcrowding on 4
    a_nb = 8'b0000_1111;
    tick();
    chk("death_state", 32'(a_sq), 0);
    chk("death_age",   32'(a_age), 0);
    chk("death_chg",   32'(a_chg), 1);
    a_ena = 0;

    // survival with age saturation at 3
    a_load = 1; a_s0 = 1;
    tick();
    a_load = 0;
    a_nb = 8'b0000_0011;
    a_ena = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("sat_age%0d", i), 32'(a_age), sat_exp[i]);
      chk($sformatf("sat_chg%0d", i), 32'(a_chg), 0);
    end
    a_ena = 0; a_nb = '0;
    tick();
    chk("hold_state", 32'(a_sq), 1);
    chk("hold_age",   32'(a_age), 3);

    // Generations C=4: 1 -> 2 -> 3 -> 0 despite full neighbourhood
    b_load = 1; b_s0 = 1;
    tick();
    b_load = 0;
    b_nb = 8'hFF; b_ena = 1;
    tick();
    chk("gen_s2",     32'(b_sq), 2);
    chk("gen_alive2", 32'(b_alive), 0);
    chk("gen_age2",   32'(b_age), 0);
    chk("gen_chg2",   32'(b_chg), 1);
    tick();
    chk("gen_s3",     32'(b_sq), 3);
    chk("gen_alive3", 32'(b_alive), 0);
    chk("gen_sd3",    32'(b_sd), 0);
    tick();
    chk("gen_s0",     32'(b_sq), 0);
    b_ena = 0;

    // C=3: last dying state wraps to dead; out-of-range load clears
    c_load = 1; c_s0 = 2;
    tick();
    chk("c3_load2", 32'(c_sq), 2);
    c_s0 = 3;
    tick();
    c_load = 0;
    chk("c3_load3", 32'(c_sq), 0);
    chk("c3_age3",  32'(c_age), 0);
    c_load = 1; c_s0 = 2;
    tick();
    c_load = 0; c_ena = 1; c_nb = 8'b0000_0111;
    tick();
    c_ena = 0;
    chk("c3_wrap", 32'(c_sq), 0);

    // 24 neighbours: count of 24 must not alias
    d_nb = 24'h7F_FFFF;
    #1 chk("n24_23_sd", 32'(d_sd), 0);
    d_ena = 1;
    tick();
    chk("n24_23_state", 32'(d_sq), 0);
    d_nb = 24'hFF_FFFF;
    #1 chk("n24_24_sd", 32'(d_sd), 1);
    tick();
    d_ena = 0;
    chk("n24_24_state", 32'(d_sq), 1);
    chk("n24_24_age",   32'(d_age), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/life_cell_gen.md
Name: life_cell_gen

Overview:
Parametrised successor to the single Game-of-Life cell. It implements one cell of a "Generations" life-like automaton. Birth and survival rules are supplied at runtime as bit masks, and neighbourhood size and state count are set by parameters. The cell keeps a multi-state refractory (dying) sequence, a saturating age counter and a change flag. It is instantiated once per grid position by the board/grid module, which wires `alive_q` of the neighbours into `neighbors`.

Parameters:
- N_NEIGHBORS, 8, number of neighbour inputs (8 = Moore r1; 24 = Moore r2).
- NUM_STATES, 2, total cell states C (2 = classic Conway; >2 adds dying states); legal range 2..256.
- AGE_W, 8, width of the age counter.
- Derived localparams (not overridable):
  - SW = max(1, $clog2(NUM_STATES)).
  - CW = $clog2(N_NEIGHBORS+1).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ena  in  1  generation step enable.
- load  in  1  synchronous load of `state_0`; priority over `ena`.
- state_0  in  SW  initial state for load.
- birth_mask  in  N_NEIGHBORS+1  bit k=1 means a dead cell with k live neighbours is born.
- survive_mask  in  N_NEIGHBORS+1  bit k=1 means a live cell with k live neighbours stays alive.
- neighbors  in  N_NEIGHBORS  alive flags of neighbour cells.
- state_d  out  SW  combinational next state.
- state_q  out  SW  registered state.
- alive_q  out  1  equals (state_q == 1).
- age_q  out  AGE_W  consecutive generations alive, saturating.
- changed_q  out  1  1 if the last step changed `state_q`.

Behaviour:
- State encoding: 0 = dead, 1 = alive, 2..C-1 = dying/refractory.
- Live count: `count` = popcount(neighbors), CW bits, range 0..N_NEIGHBORS, no overflow. Only alive neighbours count; dying cells drive `alive_q` = 0.
- `state_d` is purely combinational from `state_q`, `neighbors` and the masks:
  - state 0: 1 if birth_mask[count], else 0.
  - state 1: 1 if survive_mask[count]; else 2 if C>2; else 0.
  - state k, 2 ≤ k < C-1: k+1, unconditionally (neighbours ignored).
  - state C-1 (C>2): 0.
  - Illegal encodings (≥C, possible when C is not a power of 2): 0.
- Reset (rst=0, asynchronous): `state_q` = 0, `age_q` = 0, `changed_q` = 0.
- Register update priority, each rising edge with rst=1:
  - load=1:
    - `state_q` ← `state_0`, or 0 if `state_0` ≥ C.
    - `age_q` ← 1 if the loaded value is 1, else 0.
    - `changed_q` ← 0.
  - else ena=1:
    - `state_q` ← `state_d`.
    - `changed_q` ← (`state_d` ≠ `state_q`).
    - `age_q` ← sat_inc(`age_q`) if `state_q`=1 and `state_d`=1; 1 if `state_d`=1 and `state_q`≠1; else 0.
    - sat_inc holds at 2^AGE_W-1.
  - else: all registers hold.
- Latency: one cycle from `ena` to new `state_q`. `state_d` is valid in the same cycle as `neighbors`.
- load and ena both high: load wins, and the step is discarded.
- rst deasserted mid-grid: all cells restart dead. The grid must `load` before stepping.
- Mask bits above N_NEIGHBORS do not exist. B0 rules (birth_mask[0]=1) are legal.

Decomposition:
- Package `life_pkg`:
  - state constants ST_DEAD=0 and ST_ALIVE=1.
  - Conway default masks B3/S23: 9'b0_0000_1000 and 9'b0_0000_1100.
  - function `clog2_min1`.
- Sub-module `popcount_n` (parameter N): a parametric adder tree producing the CW-bit count. It is reused by the grid statistics block.
- The cell contains the next-state mux, the three registers and the age saturating logic.

Test Plan:
- Reset: rst=0 with state_q previously 1 → state_q=0, age_q=0, changed_q=0 immediately, without a clock edge.
- Conway B3/S23, C=2:
  - dead cell, neighbors=8'b0000_0111, ena → state_q=1, age_q=1, changed_q=1.
  - then neighbors=8'b0000_1111 → state_q=0, age_q=0.
- Survival/age saturation: AGE_W=2, live cell, neighbors with 2 set, ena for 5 cycles → age_q sequence 2,3,3,3,3; changed_q=0 after first.
- Generations, C=4, "Brian's Brain"-style B2/S none: alive, ena → 2 → 3 → 0 over three steps regardless of neighbors=8'hFF; alive_q=0 in states 2 and 3.
- Load priority: load=1, ena=1, state_0=1, neighbors=0 → state_q=1, age_q=1, changed_q=0. With C=3 and state_0=3 → state_q=0.
- N_NEIGHBORS=24, NUM_STATES=2, birth_mask bit 24 only: all 24 neighbors set → birth; 23 set → stays dead. Checks that the count does not overflow.
